fft_stage_sequencer: RTL
========================

FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 Parameter N, default 16, FFT points; power of two, 4..1024.
REQ-002 Parameter SIZE, default 4, log2(N).
REQ-003 Parameter TIMEOUT, default 4*N, max cycles allowed per stage before a fault.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start_i  in  1  one-cycle frame request.
REQ-007 load_done_i  in  1  input buffer filled; level, sampled in LOAD.
REQ-008 stage_end_i  in  1  one-cycle pulse from the address generator: current stage fully read.
REQ-009 agen_done_i  in  1  one-cycle pulse from the address generator: DONE state reached.
REQ-010 abort_i  in  1  synchronous abort; highest priority.
REQ-011 agen_start_o  out  1  one-cycle start pulse to the address generator.
REQ-012 stage_o  out  4  current stage number, 1..SIZE+1.
REQ-013 bank_sel_o  out  1  ping-pong bank select; read bank = bank_sel_o, write bank = ~bank_sel_o.
REQ-014 busy_o  out  1  high in every state except IDLE.
REQ-015 done_o  out  1  one-cycle frame-complete pulse.
REQ-016 fault_o  out  1  sticky timeout/overrun flag; cleared only by the next accepted start_i.
REQ-017 frame_cnt_o  out  16  completed-frame count; wraps modulo 2^16.

Function
REQ-018 FSM states: IDLE, LOAD, KICK, RUN, FLUSH, FINISH; one-hot encoded.
REQ-019 IDLE -> LOAD on start_i; accepting a start clears fault_o, sets stage_o=1 and bank_sel_o=0.
REQ-020 LOAD -> KICK on the first cycle load_done_i=1; LOAD waits indefinitely otherwise.
REQ-021 KICK lasts exactly one cycle, asserts agen_start_o in that cycle, then -> RUN.
REQ-022 RUN, stage_end_i with stage_o<SIZE: stage_o+1, bank_sel_o toggled, timeout counter cleared; FSM stays in RUN.
REQ-023 RUN, stage_end_i with stage_o==SIZE: stage_o set to SIZE+1, bank_sel_o toggled; -> FLUSH.
REQ-024 FLUSH -> FINISH on agen_done_i; agen_done_i arriving in the same cycle as the entry to FLUSH is honoured on the next cycle.
REQ-025 FINISH lasts one cycle: done_o=1, frame_cnt_o+1; -> IDLE. stage_o and bank_sel_o hold their values until the next accepted start.
REQ-026 Latency: done_o is asserted exactly 1 cycle after the agen_done_i pulse is sampled in FLUSH.
REQ-027 Timeout counter: width clog2(TIMEOUT)+1; counts in RUN and FLUSH; cleared on entry to KICK and on each stage_end_i.
REQ-028 On reaching TIMEOUT: fault_o=1 and FSM -> IDLE; no done_o, frame_cnt_o unchanged.
REQ-029 start_i while busy_o=1 is ignored, except fault_o is set to 1.
REQ-030 abort_i in any state: FSM -> IDLE next cycle; stage_o, bank_sel_o, done_o and fault_o unchanged.
REQ-031 stage_end_i or agen_done_i outside RUN/FLUSH is ignored.
REQ-032 stage_end_i and a timeout in the same cycle: stage_end_i wins and the counter clears.

Reset
REQ-033 On rst_n low: state=IDLE, stage_o=1, bank_sel_o=0, agen_start_o=0, done_o=0, fault_o=0, busy_o=0, frame_cnt_o=0, timeout counter=0.
REQ-034 Reset mid-frame discards the frame and needs no extra flush cycle; start_i is accepted in the first cycle after rst_n deasserts.

Structure
REQ-035 The state encodings and the stage width (4) SHALL reside in the shared package fft_pkg.
REQ-036 The timeout counter SHALL be a sub-module, fft_watchdog (inputs clr, en; output expired), instantiated once.

Verification
REQ-037 N=16: start_i, load_done_i 3 cycles later, stage_end_i every 8 cycles (4 pulses), agen_done_i -> agen_start_o once, stage_o 1,2,3,4,5, bank_sel_o 0,1,0,1,0, single done_o, frame_cnt_o=1.
REQ-038 Stage_end_i withheld in stage 2 for TIMEOUT=64 cycles -> fault_o=1, FSM in IDLE, no done_o, frame_cnt_o unchanged.
REQ-039 start_i during RUN -> frame completes normally with fault_o=1; a later start_i clears fault_o.
REQ-040 abort_i in stage 3 -> IDLE next cycle, stage_o=3 held, busy_o=0; a new start_i resets stage_o to 1.
REQ-041 rst_n pulsed low during FLUSH -> all outputs at reset values; start_i in the first cycle after release is accepted.
REQ-042 Frame counter preset to 0xFFFF via 65535 frames (or force) plus one more frame -> frame_cnt_o=0x0000.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage sequencer: one-hot FSM encodings and stage-number width.
package fft_pkg;

   localparam int STAGE_W = 4;

   typedef enum logic [5:0] {
      S_IDLE   = 6'b000001,
      S_LOAD   = 6'b000010,
      S_KICK   = 6'b000100,
      S_RUN    = 6'b001000,
      S_FLUSH  = 6'b010000,
      S_FINISH = 6'b100000
   } state_t;

endpackage

// File: rtl/fft_watchdog.sv
// Per-stage cycle watchdog: counts while en, cleared by clr; expired is combinational once TIMEOUT counts elapse.
// No backpressure; the counter parks at TIMEOUT until cleared.
module fft_watchdog #(
   parameter int TIMEOUT = 64
)(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT) + 1;

   logic [W-1:0] cnt_q;

   assign expired = en && (cnt_q == W'(TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && !expired) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Frame-level sequencer for a ping-pong radix-2 FFT: load, kick address generator, walk SIZE stages, flush, finish.
// done_o follows the sampled agen_done_i by one cycle; abort_i overrides everything, stray pulses are ignored.
module fft_stage_sequencer
   import fft_pkg::*;
#(
   parameter int N       = 16,
   parameter int SIZE    = 4,
   parameter int TIMEOUT = 4 * N
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               load_done_i,
   input  logic               stage_end_i,
   input  logic               agen_done_i,
   input  logic               abort_i,
   output logic               agen_start_o,
   output logic [STAGE_W-1:0] stage_o,
   output logic               bank_sel_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               fault_o,
   output logic [15:0]        frame_cnt_o
);

   state_t             state_q, state_d;
   logic [STAGE_W-1:0] stage_q;
   logic               bank_q, fault_q, pend_q, pend_d;
   logic [15:0]        frame_cnt_q;
   logic               wd_clr, wd_en, wd_expired;
   logic               accept, stage_adv, timeout_hit, busy_start, last_stage, flush_go;

   assign last_stage = (stage_q == STAGE_W'(SIZE));
   // agen_done_i coinciding with the last stage_end_i is remembered for the first FLUSH cycle
   assign flush_go   = agen_done_i | pend_q;
   assign busy_start = start_i & (state_q != S_IDLE) & ~abort_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      agen_start_o = 1'b0;
      busy_o       = 1'b1;
      done_o       = 1'b0;
      wd_en        = 1'b0;
      wd_clr       = 1'b0;
      accept       = 1'b0;
      stage_adv    = 1'b0;
      timeout_hit  = 1'b0;
      pend_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy_o = 1'b0;
            if (start_i) begin
               state_d = S_LOAD;
               accept  = 1'b1;
            end
         end
         S_LOAD: begin
            if (load_done_i) begin
               state_d = S_KICK;
               wd_clr  = 1'b1;
            end
         end
         S_KICK: begin
            agen_start_o = 1'b1;
            state_d      = S_RUN;
         end
         S_RUN: begin
            wd_en = 1'b1;
            if (stage_end_i) begin
               stage_adv = 1'b1;
               wd_clr    = 1'b1;
               if (last_stage) begin
                  state_d = S_FLUSH;
                  pend_d  = agen_done_i;
               end
            end else if (wd_expired) begin
               timeout_hit = 1'b1;
               state_d     = S_IDLE;
            end
         end
         S_FLUSH: begin
            wd_en = 1'b1;
            if (flush_go) begin
               state_d = S_FINISH;
            end else if (wd_expired) begin
               timeout_hit = 1'b1;
               state_d     = S_IDLE;
            end
         end
         S_FINISH: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort_i) begin
         state_d     = S_IDLE;
         accept      = 1'b0;
         stage_adv   = 1'b0;
         timeout_hit = 1'b0;
         pend_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q     <= STAGE_W'(1);
         bank_q      <= 1'b0;
         fault_q     <= 1'b0;
         pend_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         pend_q <= pend_d;
         if (accept) begin
            stage_q <= STAGE_W'(1);
            bank_q  <= 1'b0;
            fault_q <= 1'b0;
         end else begin
            if (stage_adv) begin
               stage_q <= stage_q + 1'b1;
               bank_q  <= ~bank_q;
            end
            if (timeout_hit || busy_start) fault_q <= 1'b1;
         end
         if (state_q == S_FINISH) frame_cnt_q <= frame_cnt_q + 1'b1;
      end
   end

   fft_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   assign stage_o     = stage_q;
   assign bank_sel_o  = bank_q;
   assign fault_o     = fault_q;
   assign frame_cnt_o = frame_cnt_q;

endmodule
